// File: rtl/status_tx.sv
// Event-to-UART status reporter: queues command echoes and score updates and
// streams each one to the UART transmitter as an ASCII line.
module status_tx #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ev_valid,
  input  logic                     ev_kind,
  input  logic [15:0]              ev_data,
  input  logic                     is_transmitting,
  output logic                     transmit,
  output logic [7:0]               tx_byte,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               drop_cnt,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // UART handshake: transmit is a single-cycle start pulse with tx_byte already
  // valid; the byte is in flight from is_transmitting rising until it falls, and
  // tx_byte is held until the next pulse.
  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state, state_n;
  logic [16:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            msg_kind;
  logic [15:0]     msg_data;
  logic [2:0]      idx, idx_n;
  logic [7:0]      byte_n;
  logic            load_byte;
  logic            ignored, full, push, drop, pop, last;
  logic [16:0]     head;

  function automatic logic [7:0] hex_digit(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] cmd_letter(input logic [2:0] code);
    case (code)
      3'd1:    return 8'h41;
      3'd2:    return 8'h44;
      3'd3:    return 8'h53;
      3'd4:    return 8'h57;
      3'd5:    return 8'h43;
      3'd6:    return 8'h58;
      3'd7:    return 8'h5A;
      default: return 8'h3F;
    endcase
  endfunction

  function automatic logic [7:0] msg_byte(input logic kind, input logic [15:0] d,
                                          input logic [2:0] i);
    if (!kind) begin
      case (i)
        3'd0:    return cmd_letter(d[2:0]);
        3'd1:    return 8'h0D;
        default: return 8'h0A;
      endcase
    end else begin
      case (i)
        3'd0:    return 8'h53;
        3'd1:    return hex_digit(d[15:12]);
        3'd2:    return hex_digit(d[11:8]);
        3'd3:    return hex_digit(d[7:4]);
        3'd4:    return hex_digit(d[3:0]);
        3'd5:    return 8'h0D;
        default: return 8'h0A;
      endcase
    end
  endfunction

  // Code-0 commands are silently ignored; they never count as drops.
  assign ignored = !ev_kind && (ev_data[2:0] == 3'd0);
  assign full    = (count == FULL_CNT);
  assign push    = ev_valid && !ignored && !full;
  assign drop    = ev_valid && !ignored && full;
  assign head    = mem[rd_ptr];
  assign last    = msg_kind ? (idx == 3'd6) : (idx == 3'd2);

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    byte_n    = tx_byte;
    load_byte = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          idx_n     = 3'd0;
          byte_n    = msg_byte(head[16], head[15:0], 3'd0);
          load_byte = 1'b1;
          state_n   = SEND;
        end
      end
      SEND: state_n = WAIT_BUSY;
      WAIT_BUSY: begin
        if (is_transmitting) state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!is_transmitting) begin
          if (!last) begin
            idx_n     = idx + 3'd1;
            byte_n    = msg_byte(msg_kind, msg_data, idx + 3'd1);
            load_byte = 1'b1;
            state_n   = SEND;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 3'd0;
      tx_byte  <= 8'h00;
      msg_kind <= 1'b0;
      msg_data <= 16'h0000;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (load_byte) tx_byte <= byte_n;
      if (pop) begin
        msg_kind <= head[16];
        msg_data <= head[15:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'h01;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ev_kind, ev_data};
  end

  assign transmit   = (state == SEND);
  assign busy       = (state != IDLE);
  assign fifo_count = count;
  assign dbg_state  = state;

endmodule

// File: tb/tb_status_tx.sv
// Directed bench for status_tx: UART model, byte monitor and a linear
// sequence of steps checked with immediate assertions.
module tb_status_tx;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        ev_valid;
  logic        ev_kind;
  logic [15:0] ev_data;
  logic        is_transmitting;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        busy;
  logic [3:0]  fifo_count;
  logic [7:0]  drop_cnt;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  logic       stall = 1'b0;
  logic       prev_tx = 1'b0;
  logic       pend = 1'b0;
  int         ucnt = 0;

  status_tx #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_kind(ev_kind),
    .ev_data(ev_data), .is_transmitting(is_transmitting),
    .transmit(transmit), .tx_byte(tx_byte), .busy(busy),
    .fifo_count(fifo_count), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // UART model plus byte monitor: busy from the cycle after transmit for 20 cycles.
  initial begin
    is_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      if (transmit) begin
        got_q.push_back(tx_byte);
        check("tx_while_busy", {31'd0, is_transmitting}, 32'd0);
        check("tx_back_to_back", {31'd0, prev_tx}, 32'd0);
      end
      prev_tx = transmit;
      if (rst) begin
        ucnt = 0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          ucnt = 20;
          pend = 1'b0;
        end else if (ucnt != 0 && !stall) begin
          ucnt--;
        end
        if (transmit) pend = 1'b1;
      end
      is_transmitting = (ucnt != 0);
    end
  end

  // driver: call at a negedge; event occupies the next cycle
  task automatic drive(input logic k, input logic [15:0] d);
    ev_valid = 1'b1;
    ev_kind  = k;
    ev_data  = d;
    @(negedge clk);
    ev_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || fifo_count != 0 || is_transmitting) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, {31'd0, n < 5000}, 32'd1);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  function automatic void exp_msg(input logic k, input logic [15:0] d);
    if (!k) begin
      case (d[2:0])
        3'd1: exp_q.push_back("A");
        3'd2: exp_q.push_back("D");
        3'd3: exp_q.push_back("S");
        3'd4: exp_q.push_back("W");
        3'd5: exp_q.push_back("C");
        3'd6: exp_q.push_back("X");
        default: exp_q.push_back("Z");
      endcase
    end else begin
      exp_q.push_back("S");
      exp_q.push_back(hexc(d[15:12]));
      exp_q.push_back(hexc(d[11:8]));
      exp_q.push_back(hexc(d[7:4]));
      exp_q.push_back(hexc(d[3:0]));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic check_bytes(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_transmit"}, {31'd0, transmit}, 32'd0);
    check({tag, "_tx_byte"}, {24'd0, tx_byte}, 32'h00);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_fifo_count"}, {28'd0, fifo_count}, 32'd0);
    check({tag, "_drop_cnt"}, {24'd0, drop_cnt}, 32'd0);
  endtask

  logic       ov_kind [11];
  logic [15:0] ov_data [11];

  initial begin
    int peak;
    int waited;
    rst = 1'b1;
    ev_valid = 1'b0;
    ev_kind = 1'b0;
    ev_data = 16'h0000;
    {ov_kind[0], ov_data[0]}   = {1'b0, 16'h0001};
    {ov_kind[1], ov_data[1]}   = {1'b1, 16'hBEEF};
    {ov_kind[2], ov_data[2]}   = {1'b0, 16'h0002};
    {ov_kind[3], ov_data[3]}   = {1'b0, 16'h0003};
    {ov_kind[4], ov_data[4]}   = {1'b1, 16'h0009};
    {ov_kind[5], ov_data[5]}   = {1'b0, 16'h0004};
    {ov_kind[6], ov_data[6]}   = {1'b0, 16'h0005};
    {ov_kind[7], ov_data[7]}   = {1'b1, 16'hA5C0};
    {ov_kind[8], ov_data[8]}   = {1'b0, 16'h0007};
    {ov_kind[9], ov_data[9]}   = {1'b0, 16'h0006};
    {ov_kind[10], ov_data[10]} = {1'b1, 16'hFFFF};

    // reset state
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // command echo: rotate -> "X\r\n", first transmit two cycles after ev_valid
    drive(1'b0, 16'h0006);
    check("cmd_count_after_push", {28'd0, fifo_count}, 32'd1);
    check("cmd_no_early_tx", {31'd0, transmit}, 32'd0);
    @(negedge clk);
    check("cmd_first_tx", {31'd0, transmit}, 32'd1);
    check("cmd_first_byte", {24'd0, tx_byte}, 32'h58);
    check("cmd_busy", {31'd0, busy}, 32'd1);
    wait_idle("cmd");
    check("cmd_busy_drop", {31'd0, busy}, 32'd0);
    exp_q = '{8'h58, 8'h0D, 8'h0A};
    check_bytes("cmd");

    // score formatting
    drive(1'b1, 16'h1AF3);
    wait_idle("score1af3");
    exp_q = '{8'h53, 8'h31, 8'h41, 8'h46, 8'h33, 8'h0D, 8'h0A};
    check_bytes("score1af3");
    drive(1'b1, 16'h0000);
    wait_idle("score0000");
    exp_q = '{8'h53, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    check_bytes("score0000");

    // ignored code-0 command (upper bits set, code field zero)
    drive(1'b0, 16'h0008);
    check("ign_count", {28'd0, fifo_count}, 32'd0);
    check("ign_drop", {24'd0, drop_cnt}, 32'd0);
    repeat (5) @(negedge clk);
    check("ign_busy", {31'd0, busy}, 32'd0);
    check("ign_no_bytes", got_q.size(), 32'd0);

    // push in the same cycle as the IDLE pop
    drive(1'b0, 16'h0001);
    check("sim_count_before", {28'd0, fifo_count}, 32'd1);
    drive(1'b0, 16'h0002);
    check("sim_count_same", {28'd0, fifo_count}, 32'd1);
    check("sim_busy", {31'd0, busy}, 32'd1);
    wait_idle("sim");
    exp_q = '{8'h41, 8'h0D, 8'h0A, 8'h44, 8'h0D, 8'h0A};
    check_bytes("sim");

    // overflow: DEPTH+3 consecutive events
    peak = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      drive(ov_kind[i], ov_data[i]);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    check("ovf_peak", peak, DEPTH);
    check("ovf_count_end", {28'd0, fifo_count}, DEPTH);
    check("ovf_drop", {24'd0, drop_cnt}, 32'd2);
    wait_idle("ovf");
    check("ovf_count_zero", {28'd0, fifo_count}, 32'd0);
    for (int i = 0; i < DEPTH + 1; i++) exp_msg(ov_kind[i], ov_data[i]);
    check_bytes("ovf");

    // drop counter saturation with the UART held busy
    stall = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 16'h0001);
    check("sat_full", {28'd0, fifo_count}, DEPTH);
    for (int i = 0; i < 100; i++) drive(1'b0, 16'h0003);
    check("sat_mid", {24'd0, drop_cnt}, 32'd102);
    for (int i = 0; i < 200; i++) drive(1'b1, 16'h1234);
    check("sat_255", {24'd0, drop_cnt}, 32'd255);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("sat_reset");
    stall = 1'b0;
    rst = 1'b0;
    got_q.delete();
    @(negedge clk);

    // reset in the middle of a score message with two events queued
    drive(1'b1, 16'h1234);
    drive(1'b0, 16'h0002);
    drive(1'b0, 16'h0003);
    check("rstmid_queued", {28'd0, fifo_count}, 32'd2);
    waited = 0;
    while (got_q.size() < 3 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("rstmid_reach_byte3", {31'd0, waited < 2000}, 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("rstmid_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("rstmid_quiet", got_q.size(), 32'd3);
    check("rstmid_idle", {31'd0, busy}, 32'd0);
    drive(1'b0, 16'h0007);
    wait_idle("rstmid");
    exp_q = '{8'h53, 8'h31, 8'h32};
    exp_msg(1'b0, 16'h0007);
    check_bytes("rstmid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/status_tx.md
# status_tx

Transmit-side companion to the keyboard/button command decoder. It accepts game events (echoed commands and score updates), queues them in a small FIFO, formats each one as an ASCII line, and feeds the UART transmitter one byte at a time through its `transmit`/`tx_byte`/`is_transmitting` handshake. It sits between the game core and the `uart` instance's TX side, so the host terminal sees every accepted command and score change.

## Interface

- `DEPTH`, default 8: event FIFO depth; must be a power of two and ≥2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ev_valid`  in  1  one-cycle event strobe.
- `ev_kind`  in  1  event kind: 0 = command echo, 1 = score update.
- `ev_data`  in  16  command: `[2:0]` = code 1..7; score: 16-bit value.
- `is_transmitting`  in  1  from UART; high while a byte is on the line.
- `transmit`  out  1  one-cycle pulse to the UART to start a byte.
- `tx_byte`  out  8  byte to send; held stable from the `transmit` pulse until the byte completes.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `fifo_count`  out  $clog2(DEPTH)+1  number of queued events.
- `drop_cnt`  out  8  saturating count of rejected events.

## Operation

- Command codes: 1 'A' (left), 2 'D' (right), 3 'S' (down), 4 'W' (drop), 5 'C' (hold), 6 'X' (rotate), 7 'Z' (rotate reverse).
- Command events with code 0 are ignored. They are neither queued nor counted as drops.
- Messages:
  - Command: letter, 0x0D, 0x0A (3 bytes).
  - Score: 'S', then 4 uppercase hex digits MSB first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46), then 0x0D, 0x0A (7 bytes).
- FIFO: each entry is 17 bits `{kind, data}`. Circular read/write pointers wrap modulo DEPTH.
- Push rule: a push is accepted iff `ev_valid`, the event is not an ignored code-0 command, and `fifo_count < DEPTH` at the start of the cycle.
  - A pop in the same cycle does not free a slot for that cycle's push.
  - A rejected push increments `drop_cnt`, which saturates at 255.
- Push and pop may occur in the same cycle; `fifo_count` then stays unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the message register, set byte index 0 and length (3 or 7), and go to SEND.
  - SEND: drive `tx_byte` = message[index], assert `transmit` for this cycle only, then go to WAIT_BUSY.
  - WAIT_BUSY: stay until `is_transmitting` = 1, then go to WAIT_DONE.
  - WAIT_DONE: stay until `is_transmitting` = 0. Then, if index+1 < length, increment the index and go to SEND; otherwise go to IDLE.
- `tx_byte` is registered and changes only when entering SEND.
- Reset values: FSM in IDLE; `transmit` 0; `tx_byte` 0x00; `busy` 0; `fifo_count` 0; `drop_cnt` 0; pointers 0.
- Asserting `rst` mid-message aborts it immediately and discards all queued events. `transmit` is low while `rst` is high.

## Timing

- If `ev_valid` is high in cycle t with an empty FIFO and the FSM in IDLE:
  - `fifo_count` = 1 after edge t.
  - The pop happens in cycle t+1.
  - `transmit` is high in cycle t+2 with the first byte on `tx_byte`.
- Inter-byte gap: the next `transmit` comes 1 cycle after `is_transmitting` is sampled low in WAIT_DONE.
- Back-to-back messages: IDLE costs 1 cycle between the last byte's WAIT_DONE exit and the next SEND.
- `transmit` is never asserted while `is_transmitting` = 1. It is never high for two consecutive cycles.

## Test plan

- Bench UART model: raises `is_transmitting` 1 cycle after `transmit`, holds it for 20 cycles.
- Command echo: a single event kind=0, data=6 → bytes 0x58, 0x0D, 0x0A. First `transmit` is exactly 2 cycles after `ev_valid`; `busy` drops after the third byte.
- Score format: kind=1, data=0x1AF3 → 'S','1','A','F','3',0x0D,0x0A (0x53,0x31,0x41,0x46,0x33,0x0D,0x0A). data=0x0000 → "S0000\r\n".
- Overflow: while the first message is sending, push DEPTH+3 events on consecutive cycles.
  - The first event is popped in the cycle after its push. Of the next DEPTH+2 events, DEPTH are queued and 2 are rejected, even though no further pops occur during the burst.
  - `fifo_count` peaks at DEPTH and `drop_cnt` = 2.
  - All accepted messages are emitted in order, and `fifo_count` returns to 0.
- Ignored and simultaneous events: a code-0 command leaves `fifo_count` and `drop_cnt` unchanged. A push on the same cycle as an IDLE pop keeps `fifo_count` constant.
- Reset mid-message: assert `rst` after the 3rd byte of a score message with 2 events queued.
  - All outputs return to their reset values asynchronously.
  - After release, no further bytes are sent until a new event arrives.
- Saturation: force 300 rejected pushes → `drop_cnt` = 255.
